// File: rtl/acc_reg_file_pkg.sv
// Shared types and encodings for the accumulator register file.
package acc_reg_file_pkg;

    // Background clear sequencer states.
    typedef enum logic {
        CLR_IDLE     = 1'b0,
        CLR_CLEARING = 1'b1
    } clr_state_t;

    // RegWrite steering encodings.
    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_A    = 2'b01;
    localparam logic [1:0] RW_B    = 2'b10;
    localparam logic [1:0] RW_ACC  = 2'b11;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Background clear sequencer: walks every entry index once, low to high,
// asserting clr_en while it does so.
module reg_file_clr_seq
    import acc_reg_file_pkg::*;
#(
    parameter int D = 3
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         ClearReq,
    output logic         Busy,
    output logic         clr_en,
    output logic [D-1:0] clr_idx
);

    localparam logic [D-1:0] LAST_IDX = '1;

    clr_state_t   state;
    clr_state_t   stateNext;
    logic [D-1:0] idx;
    logic [D-1:0] idxNext;

    // State and index registers; reset parks the sequencer idle at index 0.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= CLR_IDLE;
            idx   <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
        end
    end

    // Next-state logic; the index wraps to 0 naturally on the exit transition.
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        case (state)
            CLR_IDLE: begin
                if (ClearReq) begin
                    stateNext = CLR_CLEARING;
                    idxNext   = '0;
                end
            end
            CLR_CLEARING: begin
                idxNext = idx + D'(1);
                if (idx == LAST_IDX) begin
                    stateNext = CLR_IDLE;
                end
            end
            default: begin
                stateNext = CLR_IDLE;
                idxNext   = '0;
            end
        endcase
    end

    assign Busy    = (state == CLR_CLEARING);
    assign clr_en  = Busy;
    assign clr_idx = idx;

endmodule

// File: rtl/acc_reg_file.sv
// W-bit x 2**D register file with two combinational read ports, one steered
// write port, optional write-to-read bypass, accumulator-zero flag and a
// background clear sequencer.
module acc_reg_file
    import acc_reg_file_pkg::*;
#(
    parameter int W      = 8,
    parameter int D      = 3,
    parameter int ACC    = 0,
    parameter int BYPASS = 1
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         AccRead,
    input  logic [1:0]   RegWrite,
    input  logic [D-1:0] srcA,
    input  logic [D-1:0] srcB,
    input  logic [W-1:0] writeValue,
    input  logic         ClearReq,
    output logic [W-1:0] ReadA,
    output logic [W-1:0] ReadB,
    output logic         AccZero,
    output logic         Busy
);

    localparam int          DEPTH   = 2**D;
    localparam logic [D-1:0] ACC_IDX = ACC[D-1:0];

    logic [W-1:0] regs [DEPTH];
    logic         clr_en;
    logic [D-1:0] clr_idx;
    logic         wrEn;
    logic [D-1:0] wrIdx;
    logic [D-1:0] bIdx;

    reg_file_clr_seq #(.D(D)) uClrSeq (
        .CLK      (CLK),
        .Reset    (Reset),
        .ClearReq (ClearReq),
        .Busy     (Busy),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx)
    );

    // Write steering; writes are dropped while the clear sequencer owns the array.
    always_comb begin
        wrIdx = srcA;
        case (RegWrite)
            RW_B:    wrIdx = srcB;
            RW_ACC:  wrIdx = ACC_IDX;
            default: wrIdx = srcA;
        endcase
        wrEn = (RegWrite != RW_NONE) && !clr_en;
    end

    // Storage: reset clears everything, the sequencer clears one entry per cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_en) begin
            regs[clr_idx] <= '0;
        end else if (wrEn) begin
            regs[wrIdx] <= writeValue;
        end
    end

    // Read muxes with optional same-cycle forwarding of the write data.
    always_comb begin
        bIdx  = AccRead ? ACC_IDX : srcB;
        ReadA = regs[srcA];
        ReadB = regs[bIdx];
        if ((BYPASS != 0) && wrEn) begin
            if (wrIdx == srcA) ReadA = writeValue;
            if (wrIdx == bIdx) ReadB = writeValue;
        end
    end

    // Zero flag looks at stored contents only, never at bypassed data.
    assign AccZero = (regs[ACC_IDX] == '0);

endmodule

// File: tb/tb_acc_reg_file.sv
// Bench for acc_reg_file: a BYPASS=1 and a BYPASS=0 instance share stimulus;
// an array model is checked every cycle, plus hand-computed spot checks.
module tb_acc_reg_file;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       AccRead;
    logic [1:0] RegWrite;
    logic [2:0] srcA;
    logic [2:0] srcB;
    logic [7:0] writeValue;
    logic       ClearReq;
    logic [7:0] ReadA,  ReadB,  ReadA0, ReadB0;
    logic       AccZero, Busy, AccZero0, Busy0;

    int tests  = 0;
    int failed = 0;

    // Model state: entry contents and number of clear cycles still to run.
    logic [7:0] mem [8];
    int         clrLeft = 0;
    bit         checkEn = 1'b0;

    always #5 CLK = ~CLK;

    acc_reg_file #(.W(8), .D(3), .ACC(0), .BYPASS(1)) dut (
        .CLK(CLK), .Reset(Reset), .AccRead(AccRead), .RegWrite(RegWrite),
        .srcA(srcA), .srcB(srcB), .writeValue(writeValue), .ClearReq(ClearReq),
        .ReadA(ReadA), .ReadB(ReadB), .AccZero(AccZero), .Busy(Busy)
    );

    acc_reg_file #(.W(8), .D(3), .ACC(0), .BYPASS(0)) dut0 (
        .CLK(CLK), .Reset(Reset), .AccRead(AccRead), .RegWrite(RegWrite),
        .srcA(srcA), .srcB(srcB), .writeValue(writeValue), .ClearReq(ClearReq),
        .ReadA(ReadA0), .ReadB(ReadB0), .AccZero(AccZero0), .Busy(Busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each clock edge.
    always @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'h00;
            clrLeft = 0;
        end else if (clrLeft > 0) begin
            mem[8 - clrLeft] = 8'h00;
            clrLeft = clrLeft - 1;
        end else begin
            case (RegWrite)
                2'b01: mem[srcA] = writeValue;
                2'b10: mem[srcB] = writeValue;
                2'b11: mem[0]    = writeValue;
                default: ;
            endcase
            if (ClearReq) clrLeft = 8;
        end
    end

    // Compare both instances against the model mid-cycle.
    always @(negedge CLK) begin
        if (checkEn) begin
            logic       wAct;
            int         wIdx;
            int         bIdx;
            logic [7:0] stA, stB, expA, expB;
            wAct = (clrLeft == 0) && (RegWrite != 2'b00) && !Reset;
            wIdx = (RegWrite == 2'b01) ? int'(srcA) : (RegWrite == 2'b10) ? int'(srcB) : 0;
            bIdx = AccRead ? 0 : int'(srcB);
            stA  = mem[srcA];
            stB  = mem[bIdx];
            expA = (wAct && wIdx == int'(srcA)) ? writeValue : stA;
            expB = (wAct && wIdx == bIdx) ? writeValue : stB;
            check("ReadA",    ReadA,    expA);
            check("ReadB",    ReadB,    expB);
            check("AccZero",  AccZero,  mem[0] == 8'h00);
            check("Busy",     Busy,     clrLeft > 0);
            check("ReadA_nb", ReadA0,   stA);
            check("ReadB_nb", ReadB0,   stB);
            check("Busy_nb",  Busy0,    clrLeft > 0);
        end
    end

    task automatic setIn(input logic rst, input logic [1:0] rw, input logic [2:0] a,
                         input logic [2:0] b, input logic [7:0] wv, input logic accr,
                         input logic clr);
        @(posedge CLK);
        #1;
        Reset = rst; RegWrite = rw; srcA = a; srcB = b;
        writeValue = wv; AccRead = accr; ClearReq = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busyCnt;
        Reset = 1'b1; AccRead = 1'b0; RegWrite = 2'b00; srcA = '0; srcB = '0;
        writeValue = '0; ClearReq = 1'b0;
        setIn(0, 2'b00, 0, 0, 0, 0, 0);
        checkEn = 1'b1;

        // Preload, then reset for one cycle.
        for (int k = 0; k < 8; k++) setIn(0, 2'b01, 3'(k), 0, 8'h10 + 8'(k), 0, 0);
        setIn(1, 2'b00, 2, 5, 0, 0, 0);
        #1 check("preload_e2", ReadA, 8'h12);
        setIn(0, 2'b00, 2, 5, 0, 0, 0);
        #1;
        check("rst_ReadA", ReadA, 8'h00);
        check("rst_ReadB", ReadB, 8'h00);
        check("rst_AccZero", AccZero, 1'b1);
        check("rst_Busy", Busy, 1'b0);

        // Same-cycle bypass on both ports.
        setIn(0, 2'b01, 3, 3, 8'h5A, 0, 0);
        #1;
        check("byp_ReadA", ReadA, 8'h5A);
        check("byp_ReadB", ReadB, 8'h5A);
        check("nobyp_ReadA", ReadA0, 8'h00);
        setIn(0, 2'b00, 3, 3, 0, 0, 0);
        #1 check("nobyp_next_ReadA", ReadA0, 8'h5A);

        // Accumulator write and zero flag.
        setIn(0, 2'b11, 1, 2, 8'h07, 1, 0);
        #1;
        check("acc_ReadB", ReadB, 8'h07);
        check("acc_zero_before", AccZero, 1'b1);
        setIn(0, 2'b00, 1, 2, 0, 1, 0);
        #1;
        check("acc_zero_after", AccZero, 1'b0);
        check("acc_ReadB_stored", ReadB, 8'h07);
        setIn(0, 2'b11, 1, 2, 8'h00, 1, 0);
        setIn(0, 2'b00, 1, 2, 0, 1, 0);
        #1 check("acc_zero_again", AccZero, 1'b1);

        // Fill 1..7, clear, and try to write entry 6 during the sweep.
        for (int k = 1; k < 8; k++) setIn(0, 2'b01, 3'(k), 0, 8'hFF, 0, 0);
        setIn(0, 2'b00, 6, 0, 0, 0, 1);
        busyCnt = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc <= 7) setIn(0, 2'b01, 6, 0, 8'hAA, 0, 0);
            else          setIn(0, 2'b00, 7, 0, 0, 0, 0);
            #1;
            if (Busy) busyCnt++;
            if (cyc == 2) check("clr_no_bypass6", ReadA, 8'hFF);
            if (cyc == 8) check("clr_e7_pending", ReadA, 8'hFF);
            if (cyc == 9) check("clr_e7_done", ReadA, 8'h00);
        end
        check("clr_busy_cycles", busyCnt, 8);
        setIn(0, 2'b00, 6, 0, 0, 0, 0);
        #1 check("clr_e6_zero", ReadA, 8'h00);

        // Write together with ClearReq, then reset in the third clearing cycle.
        for (int k = 1; k < 8; k++) setIn(0, 2'b01, 3'(k), 0, 8'h40 + 8'(k), 0, 0);
        setIn(0, 2'b01, 5, 0, 8'h33, 0, 1);
        setIn(0, 2'b00, 5, 7, 0, 0, 0);
        #1;
        check("clrwr_commit", ReadA, 8'h33);
        check("clrwr_busy", Busy, 1'b1);
        setIn(0, 2'b00, 5, 7, 0, 0, 0);
        setIn(1, 2'b00, 5, 7, 0, 0, 0);
        setIn(0, 2'b00, 5, 7, 0, 0, 0);
        #1;
        check("midrst_busy", Busy, 1'b0);
        check("midrst_ReadA", ReadA, 8'h00);
        check("midrst_ReadB", ReadB, 8'h00);

        // Mixed traffic checked by the model.
        for (int n = 0; n < 80; n++) begin
            logic rst, clr;
            logic [1:0] rw;
            rst = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 14) == 0);
            rw  = rst ? 2'b00 : 2'($urandom_range(0, 3));
            setIn(rst, rw, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), clr);
        end
        setIn(0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
